// File: rtl/iob_cache_way_alloc_pkg.sv
// ==================================================================
// iob_cache_way_alloc_pkg: shared widths and FSM states for the refill allocator.
// Revision 1.0
// ==================================================================
`default_nettype none

package iob_cache_way_alloc_pkg;

  localparam int IOB_CACHE_N_WAYS        = 8;
  localparam int IOB_CACHE_NLINES_W      = 7;
  localparam int IOB_CACHE_TAG_W         = 20;
  localparam int IOB_CACHE_WORD_OFFSET_W = 3;
  localparam int IOB_CACHE_BE_DATA_W     = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INVAL  = 3'd1,
    ST_REQ    = 3'd2,
    ST_FILL   = 3'd3,
    ST_COMMIT = 3'd4
  } alloc_state_e;

endpackage

`default_nettype wire

// File: rtl/iob_cache_way_alloc_first_invalid.sv
// ==================================================================
// iob_cache_way_alloc_first_invalid: one-hot lowest invalid way, else policy choice.
// Revision 1.0
// ==================================================================
`default_nettype none

module iob_cache_way_alloc_first_invalid #(
  parameter int N_WAYS = 8
) (
  input  logic [N_WAYS-1:0] valid_bits_i,
  input  logic [N_WAYS-1:0] rep_way_sel_i,
  output logic [N_WAYS-1:0] victim_o
);

  logic [N_WAYS-1:0] lowest_zero_w;
  logic [N_WAYS-1:0] rep_low_w;

  // x & (x+1) tricks isolate the lowest clear / lowest set bit without a priority loop.
  assign lowest_zero_w = ~valid_bits_i & (valid_bits_i + N_WAYS'(1));
  // A malformed multi-hot policy vote still yields a single way.
  assign rep_low_w     = rep_way_sel_i & (~rep_way_sel_i + N_WAYS'(1));

  always_comb begin
    victim_o = lowest_zero_w;
    if (&valid_bits_i) begin
      victim_o = (rep_way_sel_i == '0) ? N_WAYS'(1) : rep_low_w;
    end
  end

endmodule

`default_nettype wire

// File: rtl/iob_cache_way_alloc.sv
// ==================================================================
// iob_cache_way_alloc: miss victim selection, line refill and tag/valid commit.
// Revision 1.0
// ==================================================================
`default_nettype none

module iob_cache_way_alloc
  import iob_cache_way_alloc_pkg::*;
#(
  parameter int N_WAYS        = IOB_CACHE_N_WAYS,
  parameter int NWAYS_W       = $clog2(N_WAYS),
  parameter int NLINES_W      = IOB_CACHE_NLINES_W,
  parameter int TAG_W         = IOB_CACHE_TAG_W,
  parameter int WORD_OFFSET_W = IOB_CACHE_WORD_OFFSET_W,
  parameter int BE_DATA_W     = IOB_CACHE_BE_DATA_W
) (
  input  logic                                    clk_i,
  input  logic                                    arst_n_i,
  input  logic                                    cke_i,
  input  logic                                    miss_valid_i,
  output logic                                    miss_ready_o,
  input  logic [TAG_W-1:0]                        miss_tag_i,
  input  logic [NLINES_W-1:0]                     miss_index_i,
  input  logic [N_WAYS-1:0]                       valid_bits_i,
  input  logic [N_WAYS-1:0]                       rep_way_sel_i,
  output logic                                    be_req_valid_o,
  input  logic                                    be_req_ready_i,
  output logic [TAG_W+NLINES_W+WORD_OFFSET_W-1:0] be_addr_o,
  input  logic                                    be_rvalid_i,
  input  logic [BE_DATA_W-1:0]                    be_rdata_i,
  output logic                                    data_we_o,
  output logic [N_WAYS-1:0]                       data_way_o,
  output logic [NLINES_W-1:0]                     data_index_o,
  output logic [WORD_OFFSET_W-1:0]                data_woff_o,
  output logic [BE_DATA_W-1:0]                    data_wdata_o,
  output logic                                    tag_we_o,
  output logic [TAG_W-1:0]                        tag_o,
  output logic                                    tag_valid_o,
  output logic                                    rep_write_en_o,
  output logic [N_WAYS-1:0]                       rep_way_hit_o,
  output logic                                    fill_done_o,
  output logic [NWAYS_W-1:0]                      fill_way_bin_o
);

  alloc_state_e              state_q, state_d;
  logic [TAG_W-1:0]          tag_q, tag_d;
  logic [NLINES_W-1:0]       index_q, index_d;
  logic [N_WAYS-1:0]         victim_q, victim_d;
  logic [WORD_OFFSET_W-1:0]  cnt_q, cnt_d;
  logic [N_WAYS-1:0]         victim_w;
  logic [NWAYS_W-1:0]        way_bin_w;

  iob_cache_way_alloc_first_invalid #(
    .N_WAYS (N_WAYS)
  ) u_first_invalid (
    .valid_bits_i  (valid_bits_i),
    .rep_way_sel_i (rep_way_sel_i),
    .victim_o      (victim_w)
  );

  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    index_d  = index_q;
    victim_d = victim_q;
    cnt_d    = cnt_q;
    if (cke_i) begin
      case (state_q)
        ST_IDLE: begin
          if (miss_valid_i) begin
            tag_d    = miss_tag_i;
            index_d  = miss_index_i;
            victim_d = victim_w;
            state_d  = ST_INVAL;
          end
        end
        ST_INVAL: state_d = ST_REQ;
        ST_REQ: begin
          if (be_req_ready_i) begin
            cnt_d   = '0;
            state_d = ST_FILL;
          end
        end
        ST_FILL: begin
          // The last beat wraps the counter back to zero on its way to COMMIT.
          if (be_rvalid_i) begin
            cnt_d = cnt_q + WORD_OFFSET_W'(1);
            if (cnt_q == '1) begin
              state_d = ST_COMMIT;
            end
          end
        end
        ST_COMMIT: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q  <= ST_IDLE;
      tag_q    <= '0;
      index_q  <= '0;
      victim_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      index_q  <= index_d;
      victim_q <= victim_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    way_bin_w = '0;
    for (int w = 0; w < N_WAYS; w++) begin
      if (victim_q[w]) begin
        way_bin_w = way_bin_w | NWAYS_W'(w);
      end
    end
  end

  assign miss_ready_o   = (state_q == ST_IDLE);
  assign be_req_valid_o = cke_i & (state_q == ST_REQ);
  assign be_addr_o      = {tag_q, index_q, {WORD_OFFSET_W{1'b0}}};
  assign data_we_o      = cke_i & be_rvalid_i & (state_q == ST_FILL);
  assign data_way_o     = victim_q;
  assign data_index_o   = index_q;
  assign data_woff_o    = cnt_q;
  assign data_wdata_o   = be_rdata_i;
  assign tag_we_o       = cke_i & ((state_q == ST_INVAL) | (state_q == ST_COMMIT));
  assign tag_o          = tag_q;
  assign tag_valid_o    = (state_q == ST_COMMIT);
  assign rep_write_en_o = cke_i & (state_q == ST_COMMIT);
  assign rep_way_hit_o  = rep_write_en_o ? victim_q : '0;
  assign fill_done_o    = cke_i & (state_q == ST_COMMIT);
  assign fill_way_bin_o = way_bin_w;

endmodule

`default_nettype wire

// File: tb/tb_iob_cache_way_alloc.sv
// ==================================================================
// tb_iob_cache_way_alloc: vector table, random misses and reset-abort sequences.
// Revision 1.0
// ==================================================================
`default_nettype none

module tb_iob_cache_way_alloc;

  localparam int N_WAYS = 8;
  localparam int NWAYS_W = 3;
  localparam int NLINES_W = 7;
  localparam int TAG_W = 20;
  localparam int WOFF_W = 3;
  localparam int DW = 32;
  localparam int BEATS = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                          arst_n_i, cke_i, miss_valid_i, miss_ready_o;
  logic [TAG_W-1:0]              miss_tag_i, tag_o;
  logic [NLINES_W-1:0]           miss_index_i, data_index_o;
  logic [N_WAYS-1:0]             valid_bits_i, rep_way_sel_i, data_way_o, rep_way_hit_o;
  logic                          be_req_valid_o, be_req_ready_i, be_rvalid_i;
  logic [TAG_W+NLINES_W+WOFF_W-1:0] be_addr_o;
  logic [DW-1:0]                 be_rdata_i, data_wdata_o;
  logic                          data_we_o, tag_we_o, tag_valid_o, rep_write_en_o, fill_done_o;
  logic [WOFF_W-1:0]             data_woff_o;
  logic [NWAYS_W-1:0]            fill_way_bin_o;

  iob_cache_way_alloc dut (
    .clk_i          (clk),
    .arst_n_i       (arst_n_i),
    .cke_i          (cke_i),
    .miss_valid_i   (miss_valid_i),
    .miss_ready_o   (miss_ready_o),
    .miss_tag_i     (miss_tag_i),
    .miss_index_i   (miss_index_i),
    .valid_bits_i   (valid_bits_i),
    .rep_way_sel_i  (rep_way_sel_i),
    .be_req_valid_o (be_req_valid_o),
    .be_req_ready_i (be_req_ready_i),
    .be_addr_o      (be_addr_o),
    .be_rvalid_i    (be_rvalid_i),
    .be_rdata_i     (be_rdata_i),
    .data_we_o      (data_we_o),
    .data_way_o     (data_way_o),
    .data_index_o   (data_index_o),
    .data_woff_o    (data_woff_o),
    .data_wdata_o   (data_wdata_o),
    .tag_we_o       (tag_we_o),
    .tag_o          (tag_o),
    .tag_valid_o    (tag_valid_o),
    .rep_write_en_o (rep_write_en_o),
    .rep_way_hit_o  (rep_way_hit_o),
    .fill_done_o    (fill_done_o),
    .fill_way_bin_o (fill_way_bin_o)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference victim choice straight from the allocation rule.
  function automatic logic [7:0] ref_victim(input logic [7:0] v, input logic [7:0] r);
    for (int i = 0; i < N_WAYS; i++) begin
      if (!v[i]) return 8'(1 << i);
    end
    if (r == 8'h00) return 8'h01;
    return r;
  endfunction

  function automatic int ref_bin(input logic [7:0] oh);
    for (int i = 0; i < N_WAYS; i++) begin
      if (oh[i]) return i;
    end
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_miss(input logic [TAG_W-1:0] tag, input logic [NLINES_W-1:0] idx,
                         input logic [7:0] vb, input logic [7:0] rep,
                         input logic [7:0] exp_way, input int exp_bin,
                         input int req_wait, input int gap_pct, input int cke_at,
                         input int abort_after);
    int beat;
    int cycles;
    int cke_low;
    bit cke_done;
    logic we_exp;
    logic [DW-1:0] d;
    beat = 0; cycles = 0; cke_low = 0; cke_done = 1'b0;

    miss_valid_i = 1'b1; miss_tag_i = tag; miss_index_i = idx;
    valid_bits_i = vb; rep_way_sel_i = rep; cke_i = 1'b1;
    be_rvalid_i = 1'b0; be_req_ready_i = 1'b0;
    @(negedge clk);
    check("accept_ready", miss_ready_o, 1);
    check("accept_no_req", be_req_valid_o, 0);
    tick();

    // Scramble the miss inputs: the DUT must already hold its own copies.
    miss_valid_i = 1'b0; valid_bits_i = 8'($urandom); rep_way_sel_i = 8'($urandom);
    miss_tag_i = TAG_W'($urandom); miss_index_i = NLINES_W'($urandom);
    be_rvalid_i = 1'b1; be_rdata_i = $urandom;
    @(negedge clk);
    check("inval_tag_we", tag_we_o, 1);
    check("inval_valid", tag_valid_o, 0);
    check("inval_way", data_way_o, exp_way);
    check("inval_ready", miss_ready_o, 0);
    check("inval_no_data_we", data_we_o, 0);
    tick();

    for (int w = 0; w <= req_wait; w++) begin
      be_req_ready_i = (w == req_wait);
      be_rvalid_i = 1'b1; be_rdata_i = $urandom;
      @(negedge clk);
      check("req_valid", be_req_valid_o, 1);
      check("req_addr", be_addr_o, {tag, idx, 3'b000});
      check("req_no_data_we", data_we_o, 0);
      tick();
    end
    be_req_ready_i = 1'b0;

    while (beat < BEATS) begin
      if (cycles >= 64) begin
        check("fill_timeout", beat, BEATS);
        break;
      end
      cycles++;
      if (!cke_done && cke_at == beat) begin
        cke_done = 1'b1;
        cke_low = 3;
      end
      cke_i = (cke_low == 0);
      if (cke_low > 0) cke_low--;
      be_rvalid_i = !cke_i || (int'($urandom_range(0, 99)) >= gap_pct);
      d = $urandom;
      be_rdata_i = d;
      @(negedge clk);
      we_exp = be_rvalid_i && cke_i;
      check("fill_we", data_we_o, we_exp);
      check("fill_no_commit", {tag_we_o, fill_done_o, rep_write_en_o}, 0);
      if (we_exp) begin
        check("fill_woff", data_woff_o, beat);
        check("fill_wdata", data_wdata_o, d);
        check("fill_way", data_way_o, exp_way);
        check("fill_index", data_index_o, idx);
      end
      tick();
      if (we_exp) beat++;
      if (abort_after >= 0 && beat == abort_after) begin
        cke_i = 1'b1; be_rvalid_i = 1'b0;
        arst_n_i = 1'b0;
        #1;
        check("abort_ready", miss_ready_o, 1);
        check("abort_strobes", {tag_we_o, fill_done_o, rep_write_en_o, be_req_valid_o, data_we_o}, 0);
        @(negedge clk);
        check("abort_way_cleared", data_way_o, 0);
        tick();
        arst_n_i = 1'b1;
        tick();
        return;
      end
    end
    cke_i = 1'b1;

    // COMMIT: a stray beat and a competing miss must both be ignored.
    be_rvalid_i = 1'b1; be_rdata_i = $urandom;
    miss_valid_i = 1'b1; miss_tag_i = ~tag; miss_index_i = ~idx;
    valid_bits_i = 8'h00; rep_way_sel_i = 8'h00;
    @(negedge clk);
    check("commit_tag_we", tag_we_o, 1);
    check("commit_valid", tag_valid_o, 1);
    check("commit_tag", tag_o, tag);
    check("commit_rep_we", rep_write_en_o, 1);
    check("commit_rep_hit", rep_way_hit_o, exp_way);
    check("commit_done", fill_done_o, 1);
    check("commit_bin", fill_way_bin_o, exp_bin);
    check("commit_no_data_we", data_we_o, 0);
    check("commit_ready", miss_ready_o, 0);
    tick();

    miss_valid_i = 1'b0;
    @(negedge clk);
    check("idle_ready", miss_ready_o, 1);
    check("idle_quiet", {tag_we_o, fill_done_o, rep_write_en_o, data_we_o, be_req_valid_o}, 0);
    check("idle_rep_hit", rep_way_hit_o, 0);
    tick();
    be_rvalid_i = 1'b0;
  endtask

  typedef struct {
    logic [7:0] vb;
    logic [7:0] rep;
    logic [7:0] way;
    int         bin;
    int         req_wait;
    int         gap;
    int         cke_at;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [7:0] vb, rep;
    vecs[0] = '{8'b1111_0111, 8'h01, 8'h08, 3, 0, 0, -1};
    vecs[1] = '{8'hFF, 8'h20, 8'h20, 5, 0, 0, -1};
    vecs[2] = '{8'hFF, 8'h00, 8'h01, 0, 1, 0, -1};
    vecs[3] = '{8'hFF, 8'h80, 8'h80, 7, 10, 0, -1};
    vecs[4] = '{8'h7F, 8'h04, 8'h80, 7, 2, 40, 3};
    vecs[5] = '{8'h00, 8'h40, 8'h01, 0, 0, 30, 0};
    vecs[6] = '{8'hBF, 8'h02, 8'h40, 6, 0, 50, 7};

    arst_n_i = 1'b0; cke_i = 1'b0; miss_valid_i = 1'b0; miss_tag_i = '0; miss_index_i = '0;
    valid_bits_i = '0; rep_way_sel_i = '0; be_req_ready_i = 1'b0; be_rvalid_i = 1'b0; be_rdata_i = '0;
    #12;
    check("rst_ready", miss_ready_o, 1);
    check("rst_bin", fill_way_bin_o, 0);
    check("rst_strobes", {be_req_valid_o, data_we_o, tag_we_o, tag_valid_o, rep_write_en_o, fill_done_o}, 0);
    check("rst_way", data_way_o, 0);
    check("rst_addr", be_addr_o, 0);
    check("rst_latches", {data_index_o, data_woff_o, tag_o, rep_way_hit_o}, 0);
    tick();
    arst_n_i = 1'b1;
    cke_i = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      check("vec_model_way", ref_victim(vecs[i].vb, vecs[i].rep), vecs[i].way);
      do_miss(TAG_W'(20'h1_2345 + i), NLINES_W'(5 + i), vecs[i].vb, vecs[i].rep,
              vecs[i].way, vecs[i].bin, vecs[i].req_wait, vecs[i].gap, vecs[i].cke_at, -1);
    end

    // Reset after five beats, then the same line refills cleanly.
    do_miss(20'hABCDE, 7'd5, 8'b1111_0111, 8'h01, 8'h08, 3, 1, 0, -1, 5);
    check("post_abort_ready", miss_ready_o, 1);
    do_miss(20'hABCDE, 7'd5, 8'b1111_0111, 8'h01, 8'h08, 3, 0, 20, -1, -1);

    // Back-to-back misses.
    do_miss(20'h00011, 7'd1, 8'hFF, 8'h10, 8'h10, 4, 0, 0, -1, -1);
    do_miss(20'h00022, 7'd1, 8'hFF, 8'h02, 8'h02, 1, 0, 0, -1, -1);

    for (int r = 0; r < 20; r++) begin
      vb = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
      rep = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
      do_miss(TAG_W'($urandom), NLINES_W'($urandom), vb, rep,
              ref_victim(vb, rep), ref_bin(ref_victim(vb, rep)),
              int'($urandom_range(0, 4)), 30,
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
